bus_arb: RTL

BUS_ARB -- requirements
Module: bus_arb

---
 rtl/bus_arb_pkg.sv | 17 +
 rtl/bus_lane.sv | 46 ++++
 rtl/bus_arb.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the instruction/data bus arbiter: FSM states,
// access-size codes and the byte-enable width.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam int BE_W = 4;

endpackage

// File: rtl/bus_lane.sv
// Byte-lane steering for data accesses: byte enables, write replication,
// read extraction and alignment check, shared by the write and read paths.
import bus_arb_pkg::*;

module bus_lane (
    input  logic [1:0]      size_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [31:0]     wd_i,
    input  logic [31:0]     rd_word_i,
    output logic [BE_W-1:0] be_o,
    output logic [31:0]     wd_o,
    output logic [31:0]     rd_o,
    output logic            misalign_o
);

    logic [31:0] shifted;

    always_comb begin
        be_o       = '0;
        wd_o       = '0;
        rd_o       = '0;
        misalign_o = 1'b0;
        shifted    = rd_word_i >> {addr_lo_i, 3'b000};
        case (size_i)
            SIZE_B: begin
                be_o = 4'b0001 << addr_lo_i;
                wd_o = {4{wd_i[7:0]}};
                rd_o = {24'h0, shifted[7:0]};
            end
            SIZE_H: begin
                be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wd_o       = {2{wd_i[15:0]}};
                rd_o       = {16'h0, shifted[15:0]};
                misalign_o = addr_lo_i[0];
            end
            SIZE_W: begin
                be_o       = 4'b1111;
                wd_o       = wd_i;
                rd_o       = shifted;
                misalign_o = |addr_lo_i;
            end
            default: misalign_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/bus_arb.sv
// Arbitrates a fetch port and a data port onto one system bus, with data
// priority, a response timeout and rejection of misaligned data accesses.
import bus_arb_pkg::*;

module bus_arb #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ibus_req,
    input  logic [31:0] ibus_addr,
    output logic [31:0] ibus_rd,
    output logic        ibus_done,
    output logic        ibus_err,
    input  logic        dbusif_req,
    input  logic        dbusif_w_rb,
    input  logic [1:0]  dbusif_size,
    input  logic [31:0] dbusif_addr,
    input  logic [31:0] dbusif_wd,
    output logic [31:0] dbusif_rd,
    output logic        dbusif_done,
    output logic        dbusif_err,
    output logic        bus_req,
    output logic        bus_w_rb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wd,
    output logic [3:0]  bus_be,
    input  logic        bus_resp,
    input  logic [31:0] bus_rd,
    input  logic        bus_err,
    output logic [1:0]  dbg_state_o
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    // Handshake: *_req are single-cycle pulses; bus_req is held until the
    // cycle bus_resp is sampled high; done pulses one cycle after completion.
    state_e      state_q;
    logic [7:0]  cnt_q;
    logic        i_pend_q, i_pend_d;
    logic [31:0] i_addr_q;
    logic        d_pend_q, d_pend_d;
    logic        d_w_rb_q;
    logic [1:0]  d_size_q;
    logic [31:0] d_addr_q, d_wd_q;

    logic        bus_req_q, bus_w_rb_q;
    logic [31:0] bus_addr_q, bus_wd_q;
    logic [3:0]  bus_be_q;
    logic [31:0] ibus_rd_q, dbus_rd_q;
    logic        ibus_done_q, ibus_err_q, dbus_done_q, dbus_err_q;

    logic        i_avail, d_avail, timeout, i_fin, d_fin;
    logic [31:0] i_addr_eff, d_addr_eff, d_wd_eff;
    logic        d_w_rb_eff;
    logic [1:0]  d_size_eff;
    logic [3:0]  lane_be;
    logic [31:0] lane_wd, lane_rd;
    logic        lane_misalign;

    // A request arriving this cycle is visible to the arbiter immediately.
    assign i_avail    = i_pend_q | ibus_req;
    assign i_addr_eff = i_pend_q ? i_addr_q : ibus_addr;
    assign d_avail    = d_pend_q | dbusif_req;
    assign d_w_rb_eff = d_pend_q ? d_w_rb_q : dbusif_w_rb;
    assign d_size_eff = d_pend_q ? d_size_q : dbusif_size;
    assign d_addr_eff = d_pend_q ? d_addr_q : dbusif_addr;
    assign d_wd_eff   = d_pend_q ? d_wd_q   : dbusif_wd;

    assign timeout = (cnt_q == TO_LAST);
    assign i_fin   = (state_q == ST_BUSY_I) && (bus_resp || timeout);
    assign d_fin   = ((state_q == ST_BUSY_D) && (bus_resp || timeout)) ||
                     ((state_q == ST_IDLE) && d_avail && lane_misalign);

    bus_lane u_lane (
        .size_i     (d_size_eff),
        .addr_lo_i  (d_addr_eff[1:0]),
        .wd_i       (d_wd_eff),
        .rd_word_i  (bus_rd),
        .be_o       (lane_be),
        .wd_o       (lane_wd),
        .rd_o       (lane_rd),
        .misalign_o (lane_misalign)
    );

    always_comb begin
        i_pend_d = i_pend_q;
        d_pend_d = d_pend_q;
        if (ibus_req && !i_pend_q)   i_pend_d = 1'b1;
        if (i_fin)                   i_pend_d = 1'b0;
        if (dbusif_req && !d_pend_q) d_pend_d = 1'b1;
        if (d_fin)                   d_pend_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            i_pend_q <= 1'b0;
            i_addr_q <= '0;
            d_pend_q <= 1'b0;
            d_w_rb_q <= 1'b0;
            d_size_q <= '0;
            d_addr_q <= '0;
            d_wd_q   <= '0;
        end else begin
            i_pend_q <= i_pend_d;
            d_pend_q <= d_pend_d;
            if (ibus_req && !i_pend_q) i_addr_q <= ibus_addr;
            if (dbusif_req && !d_pend_q) begin
                d_w_rb_q <= dbusif_w_rb;
                d_size_q <= dbusif_size;
                d_addr_q <= dbusif_addr;
                d_wd_q   <= dbusif_wd;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_w_rb_q  <= 1'b0;
            bus_addr_q  <= '0;
            bus_wd_q    <= '0;
            bus_be_q    <= '0;
            ibus_rd_q   <= '0;
            ibus_done_q <= 1'b0;
            ibus_err_q  <= 1'b0;
            dbus_rd_q   <= '0;
            dbus_done_q <= 1'b0;
            dbus_err_q  <= 1'b0;
        end else begin
            ibus_done_q <= 1'b0;
            ibus_err_q  <= 1'b0;
            dbus_done_q <= 1'b0;
            dbus_err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (d_avail) begin
                        if (lane_misalign) begin
                            dbus_done_q <= 1'b1;
                            dbus_err_q  <= 1'b1;
                            dbus_rd_q   <= '0;
                        end else begin
                            state_q    <= ST_BUSY_D;
                            bus_req_q  <= 1'b1;
                            bus_w_rb_q <= d_w_rb_eff;
                            bus_addr_q <= d_addr_eff & 32'hFFFF_FFFC;
                            bus_wd_q   <= lane_wd;
                            bus_be_q   <= lane_be;
                        end
                    end else if (i_avail) begin
                        state_q    <= ST_BUSY_I;
                        bus_req_q  <= 1'b1;
                        bus_w_rb_q <= 1'b0;
                        bus_addr_q <= i_addr_eff & 32'hFFFF_FFFC;
                        bus_wd_q   <= '0;
                        bus_be_q   <= 4'b1111;
                    end
                end
                ST_BUSY_I, ST_BUSY_D: begin
                    if (bus_resp || timeout) begin
                        state_q   <= ST_IDLE;
                        bus_req_q <= 1'b0;
                        // A response in the final allowed cycle still wins over the timeout.
                        if (state_q == ST_BUSY_I) begin
                            ibus_done_q <= 1'b1;
                            ibus_err_q  <= bus_resp ? bus_err : 1'b1;
                            ibus_rd_q   <= bus_resp ? bus_rd : 32'h0;
                        end else begin
                            dbus_done_q <= 1'b1;
                            dbus_err_q  <= bus_resp ? bus_err : 1'b1;
                            dbus_rd_q   <= bus_resp ? lane_rd : 32'h0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus_req     = bus_req_q;
    assign bus_w_rb    = bus_w_rb_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wd      = bus_wd_q;
    assign bus_be      = bus_be_q;
    assign ibus_rd     = ibus_rd_q;
    assign ibus_done   = ibus_done_q;
    assign ibus_err    = ibus_err_q;
    assign dbusif_rd   = dbus_rd_q;
    assign dbusif_done = dbus_done_q;
    assign dbusif_err  = dbus_err_q;
    assign dbg_state_o = state_q;

endmodule
